// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - raster pixel stream to zero-padded 3x3 neighbourhood per pixel
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   in_valid      pixel_in is valid this cycle
//   in_sof        start of frame, qualifies the pixel at (0,0)
//   pixel_in      raster-order pixel
//   in_ready      pixel accepted when in_valid & in_ready (low only while flushing)
//   out_valid     out_window carries a window this cycle
//   out_window    slot k = 3*r+c at [k*PIXEL_WIDTH +: PIXEL_WIDTH], slot 4 is the centre
//   out_sof       window centred on (0,0)
//   out_eof       window centred on (H-1,W-1)
module line_window_buffer #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 64,
   parameter int IMG_HEIGHT  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_sof,
   input  logic [PIXEL_WIDTH-1:0]   pixel_in,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [9*PIXEL_WIDTH-1:0] out_window,
   output logic                     out_sof,
   output logic                     out_eof
);

   localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W = $clog2(NPIX + 1);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int FL_W  = $clog2(IMG_WIDTH + 1);

   localparam logic [CNT_W-1:0] IDX_FILL_END = CNT_W'(IMG_WIDTH);
   localparam logic [CNT_W-1:0] IDX_LAST     = CNT_W'(NPIX - 1);
   localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [FL_W-1:0]  FLUSH_LAST   = FL_W'(IMG_WIDTH);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t                 state;
   logic [CNT_W-1:0]       in_cnt;      // index of the next accepted pixel
   logic [ROW_W-1:0]       out_row;     // centre of the next window to emit
   logic [COL_W-1:0]       out_col;
   logic [FL_W-1:0]        flush_cnt;
   logic [COL_W-1:0]       ptr;         // shared circular address for both line buffers

   // lb_mid delays the stream by one row, lb_top by two rows.
   logic [PIXEL_WIDTH-1:0] lb_top [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] lb_mid [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] win    [9];

   logic                   accept;
   logic                   sof_accept;
   logic                   push;
   logic                   emit;
   logic [PIXEL_WIDTH-1:0] push_pix;
   logic [PIXEL_WIDTH-1:0] top_rd;
   logic [PIXEL_WIDTH-1:0] mid_rd;
   logic [PIXEL_WIDTH-1:0] win_next [9];
   logic [PIXEL_WIDTH-1:0] masked   [9];
   logic [9*PIXEL_WIDTH-1:0] window_flat;

   assign in_ready   = (state != FLUSH);
   assign accept     = in_valid & in_ready;
   assign sof_accept = accept & in_sof;

   // push: a pixel (real or virtual zero) enters the window.
   // emit: that push completes the window of the centre held in out_row/out_col.
   always_comb begin
      push = 1'b0;
      emit = 1'b0;
      case (state)
         IDLE:  push = sof_accept;
         FILL:  push = accept;
         RUN: begin
            push = accept;
            emit = accept & ~in_sof;
         end
         FLUSH: begin
            push = 1'b1;
            emit = 1'b1;
         end
         default: begin
            push = 1'b0;
            emit = 1'b0;
         end
      endcase
   end

   assign push_pix = (state == FLUSH) ? '0 : pixel_in;
   assign top_rd   = lb_top[ptr];
   assign mid_rd   = lb_mid[ptr];

   // Window shifts left; the new right column is (two rows up, one row up, incoming).
   // After pushing index q the centre slot holds index q-(W+1).
   always_comb begin
      win_next[0] = win[1];
      win_next[1] = win[2];
      win_next[2] = top_rd;
      win_next[3] = win[4];
      win_next[4] = win[5];
      win_next[5] = mid_rd;
      win_next[6] = win[7];
      win_next[7] = win[8];
      win_next[8] = push_pix;
   end

   // Border masking also removes the wrapped-row and stale-frame pixels the
   // line buffers hand back at the edges.
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         masked[k] = win_next[k];
      end
      if (out_row == '0) begin
         masked[0] = '0;
         masked[1] = '0;
         masked[2] = '0;
      end
      if (out_row == ROW_LAST) begin
         masked[6] = '0;
         masked[7] = '0;
         masked[8] = '0;
      end
      if (out_col == '0) begin
         masked[0] = '0;
         masked[3] = '0;
         masked[6] = '0;
      end
      if (out_col == COL_LAST) begin
         masked[2] = '0;
         masked[5] = '0;
         masked[8] = '0;
      end
      window_flat = '0;
      for (int k = 0; k < 9; k++) begin
         window_flat[k*PIXEL_WIDTH +: PIXEL_WIDTH] = masked[k];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         lb_top[ptr] <= lb_mid[ptr];
         lb_mid[ptr] <= push_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_cnt     <= '0;
         out_row    <= '0;
         out_col    <= '0;
         flush_cnt  <= '0;
         ptr        <= '0;
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         out_window <= '0;
         for (int k = 0; k < 9; k++) begin
            win[k] <= '0;
         end
      end else begin
         out_valid <= emit;
         out_sof   <= emit && (out_row == '0) && (out_col == '0);
         out_eof   <= emit && (out_row == ROW_LAST) && (out_col == COL_LAST);

         if (emit) begin
            out_window <= window_flat;
            if (out_col == COL_LAST) begin
               out_col <= '0;
               out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
            end else begin
               out_col <= out_col + 1'b1;
            end
         end

         if (push) begin
            for (int k = 0; k < 9; k++) begin
               win[k] <= win_next[k];
            end
            ptr <= (ptr == COL_LAST) ? '0 : ptr + 1'b1;
         end

         case (state)
            IDLE: begin
               if (sof_accept) begin
                  state   <= FILL;
                  in_cnt  <= CNT_W'(1);
                  out_row <= '0;
                  out_col <= '0;
               end
            end
            FILL, RUN: begin
               if (accept) begin
                  if (in_sof) begin
                     // Abort: the sof pixel restarts the frame as index 0.
                     state   <= FILL;
                     in_cnt  <= CNT_W'(1);
                     out_row <= '0;
                     out_col <= '0;
                  end else begin
                     in_cnt <= in_cnt + 1'b1;
                     if (state == FILL && in_cnt == IDX_FILL_END) begin
                        state <= RUN;
                     end else if (state == RUN && in_cnt == IDX_LAST) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                     end
                  end
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + 1'b1;
               if (flush_cnt == FLUSH_LAST) begin
                  state  <= IDLE;
                  in_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - self-checking bench for line_window_buffer at W=H=4
module tb_line_window_buffer;

   localparam int PW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic [PW-1:0] pixel_in;
   logic          in_ready;
   logic          out_valid;
   logic [9*PW-1:0] out_window;
   logic          out_sof;
   logic          out_eof;

   always #5 clk = ~clk;

   line_window_buffer #(
      .PIXEL_WIDTH (PW),
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .pixel_in   (pixel_in),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_window (out_window),
      .out_sof    (out_sof),
      .out_eof    (out_eof)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [71:0] cap_w [$];
   logic [1:0]  cap_f [$];   // {sof, eof}
   int acc_cnt       = 0;
   int first_acc     = -1;
   int low_cnt       = 0;
   int low_start_acc = -1;

   typedef struct {
      int          centre;
      logic [71:0] w;
      logic [1:0]  f;
   } vec_t;
   vec_t tbl [6];

   always @(negedge clk) begin
      if (out_valid) begin
         if (first_acc < 0) first_acc = acc_cnt;
         cap_w.push_back(out_window);
         cap_f.push_back({out_sof, out_eof});
      end
      if (!in_ready) begin
         if (low_cnt == 0) low_start_acc = acc_cnt;
         low_cnt++;
      end
      if (in_valid && in_ready && !rst) acc_cnt++;
   end

   function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
      logic [71:0] r;
      r = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
      return r;
   endfunction

   // Reference window: direct 2-D lookup with zero outside the image.
   function automatic logic [71:0] gold(input int base, input int c);
      logic [71:0] r;
      int row;
      int col;
      int rr;
      int cc;
      r   = '0;
      row = c / W;
      col = c % W;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = row + dr;
            cc = col + dc;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
               r[((dr + 1) * 3 + dc + 1) * 8 +: 8] = 8'(base + rr * W + cc + 1);
         end
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      cap_w.delete();
      cap_f.delete();
      acc_cnt       = 0;
      first_acc     = -1;
      low_cnt       = 0;
      low_start_acc = -1;
   endtask

   task automatic send_pixel(input logic [7:0] pix, input logic sof, input bit gaps);
      while (gaps && $urandom_range(0, 1) == 0) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_sof   = sof;
      pixel_in = pix;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit gaps);
      for (int i = 0; i < W * H; i++) begin
         send_pixel(8'(base + i + 1), (i == 0), gaps);
      end
   endtask

   task automatic wait_caps(input int n);
      for (int i = 0; i < 300 && cap_w.size() < n; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string tag, input int base);
      wait_caps(16);
      chk({tag, "_count"}, 72'(cap_w.size()), 72'd16);
      chk({tag, "_latency"}, 72'(first_acc), 72'd6);
      chk({tag, "_ready_low"}, 72'(low_cnt), 72'd5);
      chk({tag, "_ready_low_start"}, 72'(low_start_acc), 72'd16);
      for (int i = 0; i < 16 && i < cap_w.size(); i++) begin
         chk($sformatf("%s_win%0d", tag, i), cap_w[i], gold(base, i));
         chk($sformatf("%s_flags%0d", tag, i), 72'(cap_f[i]), 72'({i == 0, i == 15}));
      end
   endtask

   task automatic check_table(input string tag);
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].centre < cap_w.size()) begin
            chk($sformatf("%s_tbl_win%0d", tag, tbl[i].centre), cap_w[tbl[i].centre], tbl[i].w);
            chk($sformatf("%s_tbl_flags%0d", tag, tbl[i].centre), 72'(cap_f[tbl[i].centre]), 72'(tbl[i].f));
         end else begin
            chk($sformatf("%s_tbl_missing%0d", tag, tbl[i].centre), 72'(cap_w.size()), 72'(tbl[i].centre + 1));
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 72'(out_valid), 72'd0);
      chk({tag, "_in_ready"}, 72'(in_ready), 72'd1);
      chk({tag, "_out_sof"}, 72'(out_sof), 72'd0);
      chk({tag, "_out_eof"}, 72'(out_eof), 72'd0);
      chk({tag, "_out_window"}, out_window, 72'd0);
   endtask

   initial begin
      tbl[0] = '{0,  pk(0, 0, 0, 0, 1, 2, 0, 5, 6),          2'b10};
      tbl[1] = '{5,  pk(1, 2, 3, 5, 6, 7, 9, 10, 11),        2'b00};
      tbl[2] = '{15, pk(11, 12, 0, 15, 16, 0, 0, 0, 0),      2'b01};
      tbl[3] = '{7,  pk(3, 4, 0, 7, 8, 0, 11, 12, 0),        2'b00};
      tbl[4] = '{12, pk(0, 9, 10, 0, 13, 14, 0, 0, 0),       2'b00};
      tbl[5] = '{3,  pk(0, 0, 0, 3, 4, 0, 7, 8, 0),          2'b00};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      pixel_in = '0;
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Full frame, continuous valid.
      clear_mon();
      send_frame(0, 1'b0);
      check_frame("cont", 0);
      check_table("cont");

      // Same frame with random valid gaps.
      clear_mon();
      send_frame(0, 1'b1);
      check_frame("gaps", 0);

      // Pixels without sof while idle are dropped.
      clear_mon();
      for (int i = 0; i < 5; i++) send_pixel(8'(200 + i), 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("idle_junk_count", 72'(cap_w.size()), 72'd0);
      clear_mon();
      send_frame(50, 1'b0);
      check_frame("after_junk", 50);

      // Mid-frame sof at index 9 aborts the old frame.
      clear_mon();
      for (int i = 0; i < 9; i++) send_pixel(8'(i + 1), (i == 0), 1'b0);
      send_frame(100, 1'b0);
      wait_caps(20);
      chk("abort_count", 72'(cap_w.size()), 72'd20);
      chk("abort_latency", 72'(first_acc), 72'd6);
      for (int i = 0; i < 4 && i < cap_w.size(); i++)
         chk($sformatf("abort_old_win%0d", i), cap_w[i], gold(0, i));
      if (cap_w.size() > 4) begin
         chk("abort_new_first", cap_w[4], pk(0, 0, 0, 0, 101, 102, 0, 105, 106));
         chk("abort_new_first_sof", 72'(cap_f[4]), 72'd2);
      end else begin
         chk("abort_new_missing", 72'(cap_w.size()), 72'd5);
      end
      for (int i = 0; i < 16 && i + 4 < cap_w.size(); i++)
         chk($sformatf("abort_new_win%0d", i), cap_w[i + 4], gold(100, i));

      // Reset during flush, then a clean frame.
      clear_mon();
      send_frame(0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("flush_rst");
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_rst_quiet", 72'(out_valid), 72'd0);
      clear_mon();
      send_frame(0, 1'b0);
      check_frame("post_rst", 0);
      check_table("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
